sdram_req_bridge: RTL and testbench
===================================

Name: sdram_req_bridge

Overview:
- Upstream front-end for the SDRAM controller. Queues system read/write commands in a small FIFO.
- Presents the head entry to the controller with a level req / pulse ack handshake.
- Returns read data on a fixed-latency response port.
- Monitors the ack latency and raises sticky error flags.

Parameters:
ADDR_WIDTH, 23, command address width ({bank,row,col}), equals controller address width
DATA_WIDTH, 32, read/write data width
DEPTH, 4, command FIFO entries; power of 2, >=2
RD_LAT, 12, cycles from the ack cycle to read data valid at the controller rd_data; >=1
ACK_TIMEOUT, 65535, max cycles req may wait for ack before timeout_err sets; covers controller init

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_we  in  1  1 write, 0 read
cmd_addr  in  ADDR_WIDTH  command address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  one-cycle read-data valid pulse
rsp_data  out  DATA_WIDTH  read data
ctrl_req  out  1  request to controller
ctrl_ack  in  1  controller accepted head entry (one-cycle pulse)
ctrl_addr  out  ADDR_WIDTH  head address
ctrl_wr_en  out  1  head we
ctrl_wr_data  out  DATA_WIDTH  head write data
ctrl_rd_data  in  DATA_WIDTH  controller read data
ctrl_rd_ready  out  1  tied 1
timeout_err  out  1  sticky: ack wait exceeded ACK_TIMEOUT
proto_err  out  1  sticky: ack seen while ctrl_req low

Behaviour:
- Reset values:
  - FIFO empty, pointers 0.
  - cmd_ready=1, ctrl_req=0, rsp_valid=0, rsp_data=0.
  - Errors 0, latency pipe cleared, FSM=S_IDLE.
  - ctrl_addr, ctrl_wr_en and ctrl_wr_data read 0 when empty.
- FIFO storage:
  - Entry is {we,addr,wdata}, with pointers of log2(DEPTH)+1 bits; full/empty come from the MSB compare.
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready is combinational !full, so there is no push when full, even if a pop occurs in the same cycle.
- Head outputs:
  - ctrl_addr, ctrl_wr_en and ctrl_wr_data come combinationally from the head entry.
  - They must hold stable while ctrl_req=1 until ack.
- Pop and empty/full boundaries:
  - Pop on ctrl_ack&&ctrl_req; the next entry appears on the head outputs the following cycle.
  - Push and pop in the same cycle (not full): occupancy is unchanged.
  - Push into an empty FIFO: ctrl_req rises in the next cycle (registered).
- FSM states:
  - S_IDLE: ctrl_req=0. Go to S_REQ when the FIFO is non-empty (registered, so one cycle after the first push).
  - S_REQ: ctrl_req=1 and the timeout counter increments each cycle.
    - On ack: pop, clear the counter, go to S_GAP.
    - If the counter reaches ACK_TIMEOUT: set timeout_err and stay in S_REQ (req held, counter saturates).
  - S_GAP: one cycle with ctrl_req=0 so the controller never sees a stale req after the pop. Then go to S_REQ if non-empty, else S_IDLE.
  - ack in S_IDLE or S_GAP: no pop, set proto_err.
- Read return:
  - On a pop of a read entry, insert 1 into an RD_LAT-deep shift register; insert 0 otherwise.
  - Read acked in cycle N: rsp_data<=ctrl_rd_data at the edge ending cycle N+RD_LAT-1, and rsp_valid=1 for exactly cycle N+RD_LAT.
  - Responses are in order; there is no backpressure on rsp.
  - Overlapping reads are tracked independently.
  - rsp_data holds its last value when rsp_valid=0.
- Writes produce no response.
- Reset mid-operation: queue and latency pipe are flushed, no pending rsp_valid is emitted, and the errors clear.

Optional Feature:
- Macro: SDRAM_REQ_BRIDGE_STATS_EN.
- Defined:
  - Adds outputs stat_rd_cnt[15:0] and stat_wr_cnt[15:0].
  - Each increments on a popped read/write, wraps 0xFFFF->0, and resets to 0.
  - Adds output stat_max_occ[log2(DEPTH):0], the high-water FIFO occupancy.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single write: push {we=1,addr=0x12345,wdata=0xDEADBEEF}, ack 5 cycles after req rises.
  - ctrl_req rises 1 cycle after the push and ctrl_addr=0x12345 is held until ack.
  - One cycle of req=0 follows, with no rsp_valid.
- Single read with RD_LAT=12: ack in cycle N, drive ctrl_rd_data=0xCAFEF00D during cycle N+11.
  - rsp_valid=1 only in cycle N+12, rsp_data=0xCAFEF00D.
- Fill and back-to-back:
  - Push 5 commands with DEPTH=4: cmd_ready=0 after the 4th, and the 5th is held off until the first ack.
  - All 5 reach ctrl in order, and read responses come out in order.
- Timeout: with ACK_TIMEOUT=10, push one read and never ack.
  - timeout_err=1 after 10 req cycles and stays set while req is held.
  - A later ack pops normally, and timeout_err remains set.
- Protocol error: pulse ctrl_ack with the FIFO empty.
  - proto_err=1, no pointer change, no rsp.
- Reset mid-read: assert reset 3 cycles after a read ack.
  - All outputs return to reset values and no rsp_valid ever appears.
  - With STATS_EN, the counters read 0.

Source files
------------

// File: rtl/sdram_req_bridge_if.sv
// sdram_req_bridge_if: command, controller and status bundle of the bridge.
// slave is the bridge side, master is the system/controller side.
interface sdram_req_bridge_if #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  ctrl_req;
    logic                  ctrl_ack;
    logic [ADDR_WIDTH-1:0] ctrl_addr;
    logic                  ctrl_wr_en;
    logic [DATA_WIDTH-1:0] ctrl_wr_data;
    logic [DATA_WIDTH-1:0] ctrl_rd_data;
    logic                  ctrl_rd_ready;
    logic                  timeout_err;
    logic                  proto_err;

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  ctrl_ack, ctrl_rd_data,
        output cmd_ready, rsp_valid, rsp_data,
        output ctrl_req, ctrl_addr, ctrl_wr_en,
        output ctrl_wr_data, ctrl_rd_ready,
        output timeout_err, proto_err
    );

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output ctrl_ack, ctrl_rd_data,
        input  cmd_ready, rsp_valid, rsp_data,
        input  ctrl_req, ctrl_addr, ctrl_wr_en,
        input  ctrl_wr_data, ctrl_rd_ready,
        input  timeout_err, proto_err
    );
endinterface

// File: rtl/sdram_req_bridge.sv
// sdram_req_bridge: command FIFO with req/ack front-end to the SDRAM controller.
// Define SDRAM_REQ_BRIDGE_STATS_EN to add read/write/occupancy statistics.
module sdram_req_bridge #(
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int RD_LAT      = 12,
    parameter int ACK_TIMEOUT = 65535
) (
    input logic clk,
    input logic reset,
    sdram_req_bridge_if.slave bus
`ifdef SDRAM_REQ_BRIDGE_STATS_EN
    ,
    output logic [15:0]           stat_rd_cnt,
    output logic [15:0]           stat_wr_cnt,
    output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wptr, rptr;
    logic            full, empty;
    logic            push, pop, pop_rd;
    logic [EW-1:0]   head;
    logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
    logic            terr_set;
    logic [RD_LAT-1:0] rd_pipe;
    logic [RD_LAT:0]   rd_tap;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    assign bus.cmd_ready     = !full;
    assign bus.ctrl_rd_ready = 1'b1;
    assign bus.ctrl_req      = (state == S_REQ);

    assign push   = bus.cmd_valid && !full;
    assign pop    = bus.ctrl_ack && bus.ctrl_req;
    assign head   = empty ? '0 : mem[rptr[AW-1:0]];
    assign pop_rd = pop && !head[EW-1];

    assign bus.ctrl_wr_en   = head[EW-1];
    assign bus.ctrl_addr    = head[EW-2 -: ADDR_WIDTH];
    assign bus.ctrl_wr_data = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // The wait counter saturates so a stuck controller keeps req asserted.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        terr_set     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty || push) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.ctrl_ack) begin
                    state_nxt = S_GAP;
                end else if (wait_cnt >= CW'(ACK_TIMEOUT - 1)) begin
                    wait_cnt_nxt = CW'(ACK_TIMEOUT);
                    terr_set     = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_GAP: begin
                state_nxt = (!empty || push) ? S_REQ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.timeout_err <= 1'b0;
            bus.proto_err   <= 1'b0;
        end else begin
            if (terr_set) bus.timeout_err <= 1'b1;
            if (bus.ctrl_ack && !bus.ctrl_req) bus.proto_err <= 1'b1;
        end
    end

    // rd_tap[k] marks a read acked k cycles ago; data is caught one cycle early.
    assign rd_tap        = {rd_pipe, pop_rd};
    assign bus.rsp_valid = rd_tap[RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe      <= '0;
            bus.rsp_data <= '0;
        end else begin
            rd_pipe <= rd_tap[RD_LAT-1:0];
            if (rd_tap[RD_LAT-1]) bus.rsp_data <= bus.ctrl_rd_data;
        end
    end

`ifdef SDRAM_REQ_BRIDGE_STATS_EN
    logic [AW:0] occ;

    assign occ = wptr - rptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_rd_cnt  <= '0;
            stat_wr_cnt  <= '0;
            stat_max_occ <= '0;
        end else begin
            if (pop && head[EW-1])  stat_wr_cnt <= stat_wr_cnt + 1'b1;
            if (pop && !head[EW-1]) stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (occ > stat_max_occ) stat_max_occ <= occ;
        end
    end
`endif
endmodule

// File: tb/tb_sdram_req_bridge.sv
// tb_sdram_req_bridge: directed table, corner sequences and random traffic
// checked every cycle against a queue-based model of the bridge.
module tb_sdram_req_bridge;
    localparam int AW    = 23;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int RDL   = 12;
    localparam int TO    = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdram_req_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef SDRAM_REQ_BRIDGE_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt;
    logic [2:0]  stat_max_occ;
`endif

    sdram_req_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .RD_LAT(RDL), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef SDRAM_REQ_BRIDGE_STATS_EN
        ,
        .stat_rd_cnt(stat_rd_cnt),
        .stat_wr_cnt(stat_wr_cnt),
        .stat_max_occ(stat_max_occ)
`endif
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cmd_t        q[$];
    int          due[$];
    bit          m_gap, m_terr, m_perr;
    int          m_wait, m_max;
    logic [DW-1:0] m_rsp;
    logic [15:0] m_rd, m_wr;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic drive(logic v, logic we, logic [AW-1:0] a,
                         logic [DW-1:0] d, logic ack, logic [DW-1:0] rdd);
        bus.cmd_valid    = v;
        bus.cmd_we       = we;
        bus.cmd_addr     = a;
        bus.cmd_wdata    = d;
        bus.ctrl_ack     = ack;
        bus.ctrl_rd_data = rdd;
    endtask

    function automatic bit m_req();
        return !m_gap && q.size() > 0;
    endfunction

    task automatic check_all();
        cmd_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk("cmd_ready", bus.cmd_ready, q.size() < DEPTH);
        chk("ctrl_req", bus.ctrl_req, m_req());
        chk("ctrl_addr", bus.ctrl_addr, h.addr);
        chk("ctrl_wr_en", bus.ctrl_wr_en, h.we);
        chk("ctrl_wr_data", bus.ctrl_wr_data, h.wdata);
        chk("ctrl_rd_ready", bus.ctrl_rd_ready, 1);
        chk("rsp_valid", bus.rsp_valid,
            due.size() > 0 && due[0] == cyc);
        chk("rsp_data", bus.rsp_data, m_rsp);
        chk("timeout_err", bus.timeout_err, m_terr);
        chk("proto_err", bus.proto_err, m_perr);
`ifdef SDRAM_REQ_BRIDGE_STATS_EN
        chk("stat_rd_cnt", stat_rd_cnt, m_rd);
        chk("stat_wr_cnt", stat_wr_cnt, m_wr);
        chk("stat_max_occ", stat_max_occ, m_max);
`endif
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic advance();
        bit req, push, pop;
        req  = m_req();
        push = bus.cmd_valid && q.size() < DEPTH;
        pop  = bus.ctrl_ack && req;
        if (bus.ctrl_ack && !req) m_perr = 1;
        if (req && !bus.ctrl_ack) begin
            m_wait++;
            if (m_wait >= TO) m_terr = 1;
        end else begin
            m_wait = 0;
        end
        if (due.size() > 0 && due[0] == cyc) void'(due.pop_front());
        if (due.size() > 0 && due[0] == cyc + 1) m_rsp = bus.ctrl_rd_data;
        if (q.size() > m_max) m_max = q.size();
        if (pop) begin
            if (q[0].we) m_wr++;
            else begin
                m_rd++;
                due.push_back(cyc + RDL);
            end
            void'(q.pop_front());
        end
        if (push) q.push_back({bus.cmd_we, bus.cmd_addr, bus.cmd_wdata});
        m_gap = pop;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(logic ack);
        drive(0, 0, '0, '0, ack, $urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(0);
        q.delete();
        due.delete();
        m_gap = 0; m_terr = 0; m_perr = 0;
        m_wait = 0; m_max = 0; m_rsp = '0;
        m_rd = '0; m_wr = '0;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    typedef struct {
        logic          v, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          ack;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_ready, e_perr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, pushed, popped, seen;
        bit ack;

        tbl[0] = '{1, 1, 23'h12345, 32'hDEADBEEF, 0, 0, 0, 1, 0};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{0, 0, 0, 0, 0, 1, 23'h12345, 1, 0};
        tbl[6] = '{0, 0, 0, 0, 1, 1, 23'h12345, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[8] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

        idle(0);
        do_reset();

        // single write + ack on an empty FIFO
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d,
                  tbl[i].ack, $urandom);
            settle();
            chk("tbl_req", bus.ctrl_req, tbl[i].e_req);
            chk("tbl_addr", bus.ctrl_addr, tbl[i].e_addr);
            chk("tbl_ready", bus.cmd_ready, tbl[i].e_ready);
            chk("tbl_perr", bus.proto_err, tbl[i].e_perr);
            chk("tbl_rsp", bus.rsp_valid, 0);
            advance();
        end

        // single read with fixed latency
        do_reset();
        drive(1, 0, 23'h2A5A5, '0, 0, $urandom);
        settle(); advance();
        idle(0); settle(); advance();
        idle(1); settle(); advance();
        for (int k = 1; k <= 14; k++) begin
            drive(0, 0, '0, '0, 0,
                  (k == 11) ? 32'hCAFEF00D : $urandom);
            settle();
            if (k == 11) chk("rd_early", bus.rsp_valid, 0);
            if (k == 12) begin
                chk("rd_valid", bus.rsp_valid, 1);
                chk("rd_data", bus.rsp_data, 32'hCAFEF00D);
            end
            if (k == 13) begin
                chk("rd_pulse", bus.rsp_valid, 0);
                chk("rd_hold", bus.rsp_data, 32'hCAFEF00D);
            end
            advance();
        end

        // fill to full, 5th held off until the first ack
        do_reset();
        pushed = 0;
        popped = 0;
        for (int k = 0; k < 80 && (popped < 5 || due.size() > 0); k++) begin
            ack = m_req() && k >= 5;
            drive(pushed < 5, pushed[0], 23'h100 + 23'(pushed),
                  $urandom, ack, $urandom);
            settle();
            if (k == 4) chk("fill_full", bus.cmd_ready, 0);
            if (k == 5) chk("fill_pop_no_push", bus.cmd_ready, 0);
            if (k == 6) chk("fill_ready_back", bus.cmd_ready, 1);
            if (pushed < 5 && q.size() < DEPTH) pushed++;
            if (ack) popped++;
            advance();
        end
        chk("fill_popped", popped, 5);
        chk("fill_rsp_done", due.size(), 0);

        // timeout while req is held, then a late ack
        do_reset();
        drive(1, 0, 23'h777, '0, 0, $urandom);
        settle(); advance();
        for (int k = 1; k <= 13; k++) begin
            idle(0);
            settle();
            if (k == 10) chk("to_not_yet", bus.timeout_err, 0);
            if (k == 11) chk("to_set", bus.timeout_err, 1);
            chk("to_req_held", bus.ctrl_req, 1);
            advance();
        end
        idle(1); settle(); advance();
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            idle(0); settle();
            if (bus.rsp_valid) seen++;
            advance();
        end
        chk("to_sticky", bus.timeout_err, 1);
        chk("to_late_rsp", seen, 1);

        // reset 3 cycles after a read ack
        do_reset();
        drive(1, 0, 23'h3AB, '0, 0, $urandom);
        settle(); advance();
        idle(1); settle(); advance();
        idle(0); settle(); advance();
        idle(0); settle(); advance();
        do_reset();
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            idle(0); settle();
            if (bus.rsp_valid) seen++;
            advance();
        end
        chk("rst_no_rsp", seen, 0);
        chk("rst_err_clear", bus.timeout_err | bus.proto_err, 0);

        // random traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            n = $urandom_range(0, 3);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  23'($urandom), $urandom, n == 0, $urandom);
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
